// File: rtl/muldiv_issue_ctrl_if.sv
// Decode-side bundle for the MUL/DIV issue controller: instruction/operands in, stall and result out.
interface muldiv_issue_ctrl_if #(
  parameter int XLEN = 32
);
  logic            issue_valid;
  logic            issue_is_div;
  logic [2:0]      issue_sel;
  logic [4:0]      issue_rd;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            hold;
  logic            flush;
  logic            stall;
  logic            result_valid;
  logic [XLEN-1:0] result;
  logic [4:0]      result_rd;

  modport master (
    output issue_valid, issue_is_div, issue_sel, issue_rd, op_a, op_b, hold, flush,
    input  stall, result_valid, result, result_rd
  );

  modport slave (
    input  issue_valid, issue_is_div, issue_sel, issue_rd, op_a, op_b, hold, flush,
    output stall, result_valid, result, result_rd
  );
endinterface

// File: rtl/muldiv_issue_ctrl.sv
// Issues MUL/DIV instructions from decode to the shared iterative units, stalls decode until
// the result is ready, and resolves RISC-V divide-by-zero / signed-overflow cases locally.
module muldiv_issue_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  muldiv_issue_ctrl_if.slave dec,
  output logic             mul_start,
  output logic             div_start,
  output logic [XLEN-1:0]  unit_a,
  output logic [XLEN-1:0]  unit_b,
  output logic [2:0]       unit_sel,
  output logic             unit_kill,
  input  logic             mul_done,
  input  logic [XLEN-1:0]  mul_res,
  input  logic             div_done,
  input  logic [XLEN-1:0]  div_res,
  output logic [CNT_W-1:0] perf_stall_cnt
);

  typedef enum logic [2:0] {IDLE, MUL_BUSY, DIV_BUSY, FAST, DONE} state_t;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state, state_next;
  logic            capture, mul_go, div_go, kill_go, res_load, stall;
  logic [XLEN-1:0] res_next, result_q;
  logic [4:0]      rd_q;

  // Divide special cases, judged on live operands: sel[0]=unsigned, sel[1]=remainder.
  logic            b_zero, sgn_ovf, special;
  logic [XLEN-1:0] fast_res;

  always_comb begin
    b_zero   = (dec.op_b == '0);
    sgn_ovf  = !dec.issue_sel[0] && (dec.op_a == INT_MIN) && (dec.op_b == '1);
    special  = b_zero || sgn_ovf;
    if (b_zero) fast_res = dec.issue_sel[1] ? dec.op_a : '1;
    else        fast_res = dec.issue_sel[1] ? '0 : INT_MIN;
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    mul_go     = 1'b0;
    div_go     = 1'b0;
    kill_go    = 1'b0;
    res_load   = 1'b0;
    res_next   = result_q;
    stall      = 1'b0;
    unique case (state)
      IDLE: begin
        if (dec.issue_valid && !dec.flush) begin
          stall = 1'b1;
          if (!dec.hold) begin
            capture = 1'b1;
            if (!dec.issue_is_div) begin
              mul_go     = 1'b1;
              state_next = MUL_BUSY;
            end else if (special) begin
              res_load   = 1'b1;
              res_next   = fast_res;
              state_next = FAST;
            end else begin
              div_go     = 1'b1;
              state_next = DIV_BUSY;
            end
          end
        end
      end
      MUL_BUSY: begin
        stall = 1'b1;
        if (dec.flush) begin
          kill_go    = 1'b1;
          state_next = IDLE;
        end else if (mul_done) begin
          res_load   = 1'b1;
          res_next   = mul_res;
          state_next = DONE;
        end
      end
      DIV_BUSY: begin
        stall = 1'b1;
        if (dec.flush) begin
          kill_go    = 1'b1;
          state_next = IDLE;
        end else if (div_done) begin
          res_load   = 1'b1;
          res_next   = div_res;
          state_next = DONE;
        end
      end
      FAST: begin
        stall = 1'b1;
        if (dec.flush) begin
          kill_go    = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = DONE;
        end
      end
      DONE: begin
        // The decoder still presents the same instruction here, so issue_valid is not looked at.
        if (dec.flush || !dec.hold) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      mul_start      <= 1'b0;
      div_start      <= 1'b0;
      unit_kill      <= 1'b0;
      unit_a         <= '0;
      unit_b         <= '0;
      unit_sel       <= '0;
      rd_q           <= '0;
      result_q       <= '0;
      perf_stall_cnt <= '0;
    end else begin
      state     <= state_next;
      mul_start <= mul_go;
      div_start <= div_go;
      unit_kill <= kill_go;
      if (capture) begin
        unit_a   <= dec.op_a;
        unit_b   <= dec.op_b;
        unit_sel <= dec.issue_sel;
        rd_q     <= dec.issue_rd;
      end
      if (res_load) result_q <= res_next;
      if (stall) perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
    end
  end

  assign dec.stall        = stall;
  assign dec.result_valid = (state == DONE);
  assign dec.result       = result_q;
  assign dec.result_rd    = rd_q;

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Directed bench for muldiv_issue_ctrl; a 4-bit stall counter makes counter wrap reachable quickly.
module tb_muldiv_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mul_start, div_start, unit_kill;
  logic [31:0] unit_a, unit_b;
  logic [2:0]  unit_sel;
  logic        mul_done, div_done;
  logic [31:0] mul_res, div_res;
  logic [3:0]  perf_stall_cnt;

  int compare_cnt  = 0;
  int mismatch_cnt = 0;

  muldiv_issue_ctrl_if #(.XLEN(32)) dec_if ();

  muldiv_issue_ctrl #(.XLEN(32), .CNT_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .dec            (dec_if),
    .mul_start      (mul_start),
    .div_start      (div_start),
    .unit_a         (unit_a),
    .unit_b         (unit_b),
    .unit_sel       (unit_sel),
    .unit_kill      (unit_kill),
    .mul_done       (mul_done),
    .mul_res        (mul_res),
    .div_done       (div_done),
    .div_res        (div_res),
    .perf_stall_cnt (perf_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compare_cnt++;
    if (got !== exp) begin
      mismatch_cnt++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic d, input logic [2:0] s,
                               input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
    dec_if.issue_valid  = v;
    dec_if.issue_is_div = d;
    dec_if.issue_sel    = s;
    dec_if.issue_rd     = rd;
    dec_if.op_a         = a;
    dec_if.op_b         = b;
  endtask

  // Fast-path divide: two stall cycles, no divider start, result valid in the third cycle.
  task automatic runFast(input string tag, input logic [2:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input logic [3:0] exp_cnt);
    applyStimulus(1'b1, 1'b1, sel, 5'd9, a, b);
    #1;
    checkOutput({tag, "_stall0"}, 32'(dec_if.stall), 32'd1);
    tick();
    checkOutput({tag, "_stall1"}, 32'(dec_if.stall), 32'd1);
    checkOutput({tag, "_nostart"}, 32'(div_start | mul_start), 32'd0);
    tick();
    checkOutput({tag, "_valid"}, 32'(dec_if.result_valid), 32'd1);
    checkOutput({tag, "_result"}, dec_if.result, exp);
    checkOutput({tag, "_rd"}, 32'(dec_if.result_rd), 32'd9);
    checkOutput({tag, "_stall2"}, 32'(dec_if.stall), 32'd0);
    checkOutput({tag, "_cnt"}, 32'(perf_stall_cnt), 32'(exp_cnt));
    applyStimulus(1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 32'd0);
    tick();
    checkOutput({tag, "_idle"}, 32'(dec_if.result_valid | div_start), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    mul_done = 1'b0; div_done = 1'b0; mul_res = '0; div_res = '0;
    dec_if.hold = 1'b0; dec_if.flush = 1'b0;
    applyStimulus(1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 32'd0);
    repeat (2) tick();
    checkOutput("rst_stall", 32'(dec_if.stall), 32'd0);
    checkOutput("rst_valid", 32'(dec_if.result_valid), 32'd0);
    checkOutput("rst_starts", 32'(mul_start | div_start | unit_kill), 32'd0);
    checkOutput("rst_unit_a", unit_a, 32'd0);
    checkOutput("rst_cnt", 32'(perf_stall_cnt), 32'd0);
    rst = 1'b0;
    tick();

    // MUL 7*6 with the multiplier answering three cycles after its start pulse
    applyStimulus(1'b1, 1'b0, 3'd0, 5'd5, 32'd7, 32'd6);
    #1;
    checkOutput("mul_stall0", 32'(dec_if.stall), 32'd1);
    tick();
    checkOutput("mul_start1", 32'(mul_start), 32'd1);
    checkOutput("mul_divstart", 32'(div_start), 32'd0);
    checkOutput("mul_ua", unit_a, 32'd7);
    checkOutput("mul_ub", unit_b, 32'd6);
    tick();
    checkOutput("mul_start2", 32'(mul_start), 32'd0);
    checkOutput("mul_stall2", 32'(dec_if.stall), 32'd1);
    tick();
    tick();
    mul_done = 1'b1; mul_res = 32'd42;
    #1;
    checkOutput("mul_stall4", 32'(dec_if.stall), 32'd1);
    checkOutput("mul_novalid4", 32'(dec_if.result_valid), 32'd0);
    tick();
    mul_done = 1'b0;
    checkOutput("mul_valid", 32'(dec_if.result_valid), 32'd1);
    checkOutput("mul_result", dec_if.result, 32'd42);
    checkOutput("mul_rd", 32'(dec_if.result_rd), 32'd5);
    checkOutput("mul_stall5", 32'(dec_if.stall), 32'd0);
    checkOutput("mul_cnt", 32'(perf_stall_cnt), 32'd5);
    applyStimulus(1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 32'd0);
    tick();
    checkOutput("mul_idle", 32'(dec_if.result_valid), 32'd0);

    runFast("divu_z", 3'd1, 32'd100, 32'd0, 32'hFFFF_FFFF, 4'd7);
    runFast("remu_z", 3'd3, 32'd100, 32'd0, 32'd100, 4'd9);
    runFast("div_ovf", 3'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 4'd11);
    runFast("rem_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 4'd13);

    // Flush arriving together with div_done: kill pulse, result dropped
    applyStimulus(1'b1, 1'b1, 3'd0, 5'd7, 32'd200, 32'd7);
    tick();
    checkOutput("fl_divstart", 32'(div_start), 32'd1);
    checkOutput("fl_usel", 32'(unit_sel), 32'd0);
    tick();
    tick();
    applyStimulus(1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 32'd0);
    dec_if.flush = 1'b1; div_done = 1'b1; div_res = 32'd28;
    tick();
    dec_if.flush = 1'b0; div_done = 1'b0;
    checkOutput("fl_kill", 32'(unit_kill), 32'd1);
    checkOutput("fl_novalid", 32'(dec_if.result_valid), 32'd0);
    checkOutput("fl_stall", 32'(dec_if.stall), 32'd0);
    checkOutput("fl_cnt_wrap", 32'(perf_stall_cnt), 32'd1);
    tick();
    checkOutput("fl_kill_off", 32'(unit_kill), 32'd0);
    checkOutput("fl_still_idle", 32'(dec_if.result_valid), 32'd0);

    // Flush in IDLE blocks capture of the instruction
    applyStimulus(1'b1, 1'b0, 3'd0, 5'd3, 32'd1, 32'd2);
    dec_if.flush = 1'b1;
    #1;
    checkOutput("ifl_stall", 32'(dec_if.stall), 32'd0);
    tick();
    dec_if.flush = 1'b0;
    applyStimulus(1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 32'd0);
    checkOutput("ifl_nostart", 32'(mul_start), 32'd0);
    checkOutput("ifl_cnt", 32'(perf_stall_cnt), 32'd1);

    // Hold in DONE for four cycles, exit on the first hold-free cycle
    applyStimulus(1'b1, 1'b1, 3'd1, 5'd12, 32'd55, 32'd0);
    tick();
    tick();
    dec_if.hold = 1'b1;
    applyStimulus(1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 32'd0);
    checkOutput("hold_cnt", 32'(perf_stall_cnt), 32'd3);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("hold_valid%0d", i), 32'(dec_if.result_valid), 32'd1);
      checkOutput($sformatf("hold_result%0d", i), dec_if.result, 32'hFFFF_FFFF);
      checkOutput($sformatf("hold_stall%0d", i), 32'(dec_if.stall), 32'd0);
      if (i < 3) tick();
    end
    tick();
    dec_if.hold = 1'b0;
    #1;
    checkOutput("hold_last_valid", 32'(dec_if.result_valid), 32'd1);
    tick();
    checkOutput("hold_exit", 32'(dec_if.result_valid), 32'd0);

    // Reset in the middle of a divide
    applyStimulus(1'b1, 1'b1, 3'd0, 5'd4, 32'd20, 32'd3);
    tick();
    checkOutput("mr_divstart", 32'(div_start), 32'd1);
    tick();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 32'd0);
    #1;
    checkOutput("mr_stall", 32'(dec_if.stall), 32'd0);
    checkOutput("mr_pulses", 32'(div_start | unit_kill), 32'd0);
    checkOutput("mr_unit_a", unit_a, 32'd0);
    checkOutput("mr_result", dec_if.result, 32'd0);
    checkOutput("mr_cnt", 32'(perf_stall_cnt), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    checkOutput("mr_nokill", 32'(unit_kill), 32'd0);

    // Long divide: counter wraps, a stray mul_done is ignored
    applyStimulus(1'b1, 1'b1, 3'd0, 5'd4, 32'd20, 32'd3);
    tick();
    checkOutput("wr_divstart", 32'(div_start), 32'd1);
    checkOutput("wr_ua", unit_a, 32'd20);
    applyStimulus(1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 32'd0);
    repeat (14) tick();
    checkOutput("wr_cnt15", 32'(perf_stall_cnt), 32'd15);
    tick();
    mul_done = 1'b1; mul_res = 32'd99;
    tick();
    mul_done = 1'b0;
    checkOutput("wr_ignore_mul", 32'(dec_if.result_valid), 32'd0);
    checkOutput("wr_cnt_wrap", 32'(perf_stall_cnt), 32'd1);
    div_done = 1'b1; div_res = 32'd6;
    tick();
    div_done = 1'b0;
    checkOutput("wr_valid", 32'(dec_if.result_valid), 32'd1);
    checkOutput("wr_result", dec_if.result, 32'd6);
    checkOutput("wr_rd", 32'(dec_if.result_rd), 32'd4);
    checkOutput("wr_cnt_end", 32'(perf_stall_cnt), 32'd2);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, mismatch_cnt);
    $finish;
  end

endmodule
